mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one physical memory port between the instruction-fetch requester (A, read-only)
//  and the data requester (B, read/write). Sits between the datapath memory ports and the
//  unified memory. Round-robin grant with registered outputs, one transaction in flight.
// PARAMETERS
//  ADDR_WIDTH  16  width of all address buses (lc3b_word)
//  DATA_WIDTH  16  width of all data buses
// PORTS
//  clk          in   1           rising-edge clock
//  reset_n      in   1           asynchronous active-low reset
//  a_read       in   1           A read request, level, held until a_resp
//  a_address    in   ADDR_WIDTH  A address
//  a_resp       out  1           A completion pulse, 1 cycle
//  a_rdata      out  DATA_WIDTH  A read data, valid while a_resp=1
//  b_read       in   1           B read request, level, held until b_resp
//  b_write      in   1           B write request, level, held until b_resp
//  b_address    in   ADDR_WIDTH  B address
//  b_wdata      in   DATA_WIDTH  B write data
//  b_resp       out  1           B completion pulse, 1 cycle
//  b_rdata      out  DATA_WIDTH  B read data, valid while b_resp=1
//  mem_read     out  1           memory read strobe, held until mem_resp
//  mem_write    out  1           memory write strobe, held until mem_resp
//  mem_address  out  ADDR_WIDTH  memory address
//  mem_wdata    out  DATA_WIDTH  memory write data
//  mem_resp     in   1           memory completion, 1-cycle pulse
//  mem_rdata    in   DATA_WIDTH  memory read data, valid with mem_resp
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0; state IDLE; last_grant=B.
//  - States: IDLE, BUSY_A, BUSY_B, DONE. All outputs are flops.
//  - IDLE: if only A requests -> BUSY_A; only B -> BUSY_B; both -> the side != last_grant.
//    On grant, latch address (and b_wdata, op) into mem_* regs; set mem_read/mem_write;
//    last_grant<=granted side. No request: stay IDLE, mem_* strobes 0.
//  - Latency: request sampled in IDLE at edge N -> mem strobe high after edge N.
//  - BUSY_x: hold mem_* constant; requester address/data changes ignored (latched).
//    On mem_resp: drop strobes, capture mem_rdata into x_rdata, x_resp<=1, -> DONE.
//  - DONE: x_resp high exactly this cycle; requests ignored here (requester drops its
//    request on seeing resp); next state IDLE, x_resp<=0. Min 3 cycles between grants.
//  - b_read and b_write both high: treated as write (illegal; bench assertion flags it).
//  - mem_resp outside BUSY_A/BUSY_B: ignored, no state or output change.
//  - a_rdata/b_rdata hold last captured value after resp; a_rdata untouched by B ops.
//  - Continuous requests from both: strict alternation A,B,A,B; no starvation.
//  - Reset mid-transaction: abandon transfer, return to IDLE, strobes 0 immediately;
//    requesters must reissue. Lost mem_resp after reset is ignored (see above).
// TESTING
//  1. A read 0x1234, mem_resp 3 cycles after mem_read with 0xBEEF -> mem_read/address
//     0x1234 one cycle after request; a_resp 1-cycle pulse, a_rdata=0xBEEF; b_resp=0.
//  2. A and B both request from reset -> A served first, then B; hold both requesting
//     for 4 transactions -> grant order A,B,A,B.
//  3. B write 0x0040/0x5A5A -> mem_write=1, mem_address=0x0040, mem_wdata=0x5A5A until
//     mem_resp; b_resp pulse next cycle; mem_read stays 0.
//  4. B read 0x0010, change b_address to 0x0020 while BUSY_B -> mem_address stays 0x0010.
//  5. reset_n low mid-BUSY_A (between clock edges) -> all outputs 0 immediately; after
//     release, spurious mem_resp -> no a_resp/b_resp, state stays IDLE.
//  6. b_read and b_write both high, address 0x0008 -> mem_write=1, mem_read=0, assertion fires.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (A, read-only)
// and data (B, read/write); one transaction in flight, all outputs registered.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_read,
  input  logic [ADDR_WIDTH-1:0] a_address,
  output logic                  a_resp,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_read,
  input  logic                  b_write,
  input  logic [ADDR_WIDTH-1:0] b_address,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_resp,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_resp,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B, DONE} state_t;

  state_t state, next_state;
  logic   last_grant_b;
  logic   b_req, grant_a, grant_b;

  // On contention the side that did not win last time is granted.
  always_comb begin
    b_req   = b_read | b_write;
    grant_a = a_read & (~b_req | last_grant_b);
    grant_b = b_req & (~a_read | ~last_grant_b);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (grant_a)      next_state = BUSY_A;
        else if (grant_b) next_state = BUSY_B;
      end
      BUSY_A, BUSY_B: if (mem_resp) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_resp       <= 1'b0;
      a_rdata      <= '0;
      b_resp       <= 1'b0;
      b_rdata      <= '0;
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
      mem_address  <= '0;
      mem_wdata    <= '0;
      last_grant_b <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_a) begin
            mem_read     <= 1'b1;
            mem_write    <= 1'b0;
            mem_address  <= a_address;
            last_grant_b <= 1'b0;
          end else if (grant_b) begin
            // Simultaneous read and write is resolved as a write.
            mem_read     <= ~b_write;
            mem_write    <= b_write;
            mem_address  <= b_address;
            mem_wdata    <= b_wdata;
            last_grant_b <= 1'b1;
          end
        end
        BUSY_A: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            a_rdata   <= mem_rdata;
            a_resp    <= 1'b1;
          end
        end
        BUSY_B: begin
          if (mem_resp) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            b_rdata   <= mem_rdata;
            b_resp    <= 1'b1;
          end
        end
        DONE: begin
          a_resp <= 1'b0;
          b_resp <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          a_read = 1'b0;
  logic [AW-1:0] a_address = '0;
  logic          a_resp;
  logic [DW-1:0] a_rdata;
  logic          b_read = 1'b0;
  logic          b_write = 1'b0;
  logic [AW-1:0] b_address = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_resp;
  logic [DW-1:0] b_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          mem_resp = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_read(a_read), .a_address(a_address), .a_resp(a_resp), .a_rdata(a_rdata),
    .b_read(b_read), .b_write(b_write), .b_address(b_address), .b_wdata(b_wdata),
    .b_resp(b_resp), .b_rdata(b_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the port, and whether a completion is being shown.
  int            m_owner = 0;   // 0 none, 1 A, 2 B
  bit            m_showing = 1'b0;
  bit            m_last_b = 1'b1;
  logic          m_rd = 1'b0, m_wr = 1'b0, m_a_resp = 1'b0, m_b_resp = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0, m_a_rdata = '0, m_b_rdata = '0;
  bit            want_a, want_b;
  int            pick;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = 0; m_showing = 1'b0; m_last_b = 1'b1;
      m_rd = 1'b0; m_wr = 1'b0; m_a_resp = 1'b0; m_b_resp = 1'b0;
      m_a_rdata = '0; m_b_rdata = '0;
    end else begin
      m_a_resp = 1'b0;
      m_b_resp = 1'b0;
      if (m_showing) begin
        m_showing = 1'b0;
      end else if (m_owner != 0) begin
        if (mem_resp) begin
          m_rd = 1'b0; m_wr = 1'b0;
          if (m_owner == 1) begin m_a_rdata = mem_rdata; m_a_resp = 1'b1; end
          else              begin m_b_rdata = mem_rdata; m_b_resp = 1'b1; end
          m_owner = 0;
          m_showing = 1'b1;
        end
      end else begin
        want_a = a_read;
        want_b = b_read || b_write;
        pick = (want_a && want_b) ? (m_last_b ? 1 : 2) : want_a ? 1 : want_b ? 2 : 0;
        if (pick == 1) begin
          m_owner = 1; m_rd = 1'b1; m_wr = 1'b0; m_addr = a_address; m_last_b = 1'b0;
        end else if (pick == 2) begin
          m_owner = 2; m_wr = b_write; m_rd = !b_write; m_addr = b_address;
          m_wdata = b_wdata; m_last_b = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      chk("mem_read", 32'(mem_read), 32'(m_rd));
      chk("mem_write", 32'(mem_write), 32'(m_wr));
      if (m_rd || m_wr) chk("mem_address", 32'(mem_address), 32'(m_addr));
      if (m_wr) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
      chk("a_resp", 32'(a_resp), 32'(m_a_resp));
      chk("b_resp", 32'(b_resp), 32'(m_b_resp));
      chk("a_rdata", 32'(a_rdata), 32'(m_a_rdata));
      chk("b_rdata", 32'(b_rdata), 32'(m_b_rdata));
    end
  end

  // Flags the illegal simultaneous B read+write request.
  int illegal_seen = 0;
  always @(posedge clk) begin
    if (reset_n && b_read && b_write) begin
      illegal_seen++;
      $display("note: illegal b_read and b_write both high (t=%0t)", $time);
    end
  end

  // Waits (bounded) for a memory strobe, then answers after lat cycles with data d.
  task automatic serve(input int lat, input logic [DW-1:0] d,
                       output logic [AW-1:0] addr, output logic wr);
    int i = 0;
    while (!(mem_read || mem_write) && i < 20) begin step(); i++; end
    if (!(mem_read || mem_write)) begin
      checks++; errors++;
      $display("FAIL serve_timeout: no memory strobe after %0d cycles, strobe required", i);
    end
    addr = mem_address;
    wr   = mem_write;
    repeat (lat) step();
    mem_rdata = d;
    mem_resp  = 1'b1;
    step();
    mem_resp  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  logic [AW-1:0] s_addr;
  logic          s_wr;
  int            order[4];
  int            ill0;
  int            a_wait = 0, b_wait = 0, wait_cnt = 0;
  bit            quiet;

  initial begin
    repeat (2) step();
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    chk("rst_mem_write", 32'(mem_write), 32'h0);
    chk("rst_mem_address", 32'(mem_address), 32'h0);
    chk("rst_a_resp", 32'(a_resp), 32'h0);
    chk("rst_b_resp", 32'(b_resp), 32'h0);
    reset_n = 1'b1;
    step();

    // A read, memory answers 3 cycles after the strobe
    a_read = 1'b1; a_address = 16'h1234;
    step();
    chk("t1_mem_read", 32'(mem_read), 32'h1);
    chk("t1_mem_address", 32'(mem_address), 32'h1234);
    chk("t1_mem_write", 32'(mem_write), 32'h0);
    serve(2, 16'hBEEF, s_addr, s_wr);
    chk("t1_a_resp", 32'(a_resp), 32'h1);
    chk("t1_a_rdata", 32'(a_rdata), 32'hBEEF);
    chk("t1_b_resp", 32'(b_resp), 32'h0);
    chk("t1_strobe_drop", 32'(mem_read), 32'h0);
    a_read = 1'b0;
    step();
    chk("t1_a_resp_pulse", 32'(a_resp), 32'h0);
    chk("t1_a_rdata_hold", 32'(a_rdata), 32'hBEEF);

    // Both requesting from reset: A first, then strict alternation
    do_reset();
    a_read = 1'b1; b_read = 1'b1; a_address = 16'h0100; b_address = 16'h0200;
    for (int k = 0; k < 4; k++) begin
      serve(1, 16'h1000 + 16'(k), s_addr, s_wr);
      order[k] = (s_addr == 16'h0100) ? 1 : 2;
    end
    a_read = 1'b0; b_read = 1'b0;
    chk("t2_grant0", 32'(order[0]), 32'd1);
    chk("t2_grant1", 32'(order[1]), 32'd2);
    chk("t2_grant2", 32'(order[2]), 32'd1);
    chk("t2_grant3", 32'(order[3]), 32'd2);
    repeat (2) step();

    // B write
    b_write = 1'b1; b_address = 16'h0040; b_wdata = 16'h5A5A;
    step();
    chk("t3_mem_write", 32'(mem_write), 32'h1);
    chk("t3_mem_read", 32'(mem_read), 32'h0);
    chk("t3_mem_address", 32'(mem_address), 32'h0040);
    chk("t3_mem_wdata", 32'(mem_wdata), 32'h5A5A);
    serve(2, 16'h7777, s_addr, s_wr);
    chk("t3_b_resp", 32'(b_resp), 32'h1);
    chk("t3_write_drop", 32'(mem_write), 32'h0);
    b_write = 1'b0;
    repeat (2) step();

    // B read with address changing while busy
    b_read = 1'b1; b_address = 16'h0010;
    step();
    b_address = 16'h0020;
    step();
    chk("t4_mem_address_latched", 32'(mem_address), 32'h0010);
    serve(1, 16'h0BAD, s_addr, s_wr);
    chk("t4_b_rdata", 32'(b_rdata), 32'h0BAD);
    chk("t4_a_rdata_untouched", 32'(a_rdata), 32'h1002);
    b_read = 1'b0;
    repeat (2) step();

    // Reset in the middle of an A transfer, then a stray mem_resp
    a_read = 1'b1; a_address = 16'h0300;
    step();
    chk("t5_busy_a", 32'(mem_read), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_mem_read", 32'(mem_read), 32'h0);
    chk("t5_async_mem_address", 32'(mem_address), 32'h0);
    chk("t5_async_a_rdata", 32'(a_rdata), 32'h0);
    chk("t5_async_b_rdata", 32'(b_rdata), 32'h0);
    a_read = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    mem_rdata = 16'hFFFF; mem_resp = 1'b1;
    step();
    mem_resp = 1'b0;
    chk("t5_no_a_resp", 32'(a_resp), 32'h0);
    chk("t5_no_b_resp", 32'(b_resp), 32'h0);
    step();
    chk("t5_idle_mem_read", 32'(mem_read), 32'h0);
    chk("t5_idle_a_rdata", 32'(a_rdata), 32'h0);

    // b_read and b_write together resolve to a write
    ill0 = illegal_seen;
    b_read = 1'b1; b_write = 1'b1; b_address = 16'h0008; b_wdata = 16'h1111;
    step();
    chk("t6_mem_write", 32'(mem_write), 32'h1);
    chk("t6_mem_read", 32'(mem_read), 32'h0);
    chk("t6_mem_address", 32'(mem_address), 32'h0008);
    chk("t6_illegal_flagged", 32'(illegal_seen > ill0), 32'h1);
    serve(1, 16'h2222, s_addr, s_wr);
    b_read = 1'b0; b_write = 1'b0;
    repeat (2) step();

    // Randomized traffic with random memory latency and stray responses
    for (int cyc = 0; cyc < 3000; cyc++) begin
      quiet = (cyc >= 2950);
      if (a_read) begin
        if (a_resp) begin
          a_wait = 0;
          if (quiet || ($urandom % 4 != 0)) a_read = 1'b0;
          else a_address = 16'($urandom);
        end else begin
          a_wait++;
          if (a_wait > 60) begin
            checks++; errors++;
            $display("FAIL a_timeout: a_resp missing after %0d cycles, expected within 60", a_wait);
            a_read = 1'b0; a_wait = 0;
          end else if ($urandom % 4 == 0) a_address = 16'($urandom);
        end
      end else if (!quiet && ($urandom % 3 == 0)) begin
        a_read = 1'b1; a_address = 16'($urandom);
      end

      if (b_read || b_write) begin
        if (b_resp) begin
          b_wait = 0;
          if (quiet || ($urandom % 4 != 0)) begin b_read = 1'b0; b_write = 1'b0; end
          else begin b_address = 16'($urandom); b_wdata = 16'($urandom); end
        end else begin
          b_wait++;
          if (b_wait > 60) begin
            checks++; errors++;
            $display("FAIL b_timeout: b_resp missing after %0d cycles, expected within 60", b_wait);
            b_read = 1'b0; b_write = 1'b0; b_wait = 0;
          end else if ($urandom % 4 == 0) begin
            b_address = 16'($urandom); b_wdata = 16'($urandom);
          end
        end
      end else if (!quiet && ($urandom % 3 == 0)) begin
        b_write = 1'($urandom % 2);
        b_read = !b_write;
        b_address = 16'($urandom); b_wdata = 16'($urandom);
      end

      if (mem_resp) mem_resp = 1'b0;
      else if (mem_read || mem_write) begin
        if (wait_cnt == 0) begin
          mem_resp = 1'b1; mem_rdata = 16'($urandom);
          wait_cnt = int'($urandom_range(0, 3));
        end else wait_cnt--;
      end else if ($urandom % 16 == 0) begin
        mem_resp = 1'b1; mem_rdata = 16'($urandom);
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
